column_streamer: RTL and testbench
==================================

COLUMN_STREAMER -- requirements
Module: column_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 33, meaning bits per bitmap column.
REQ-002 SHALL have parameter DEPTH, default 252, meaning column storage entries.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning address and count width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  column-store write strobe.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  DATA_W  column bitmap to store.
REQ-009 start  input  1  begin streaming; single-cycle pulse.
REQ-010 num_cols  input  ADDR_W  columns to stream, sampled with start.
REQ-011 hold_cycles  input  ADDR_W  clocks each column is held, sampled with start.
REQ-012 lead_cycles  input  ADDR_W  blank clocks before first column, sampled with start.
REQ-013 col_out  output  DATA_W  registered column fed to the downstream wave stage.
REQ-014 col_valid  output  1  high while col_out carries a stored column.
REQ-015 col_idx  output  ADDR_W  index of column on col_out.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 States SHALL be IDLE, LEAD, SHOW, DONE.
REQ-019 In IDLE, LEAD and DONE, col_out SHALL be all zeros and col_valid low.
REQ-020 start in IDLE SHALL latch num_cols, hold_cycles and lead_cycles, assert busy next cycle, and enter LEAD, or SHOW if lead_cycles is 0.
REQ-021 start while busy SHALL be ignored; latched parameters unchanged.
REQ-022 hold_cycles of 0 SHALL be treated as 1.
REQ-023 num_cols above DEPTH SHALL be clamped to DEPTH.
REQ-024 num_cols of 0 SHALL go IDLE->DONE with no column shown.
REQ-025 With start sampled at edge E0, column 0 SHALL appear on col_out at edge E0+L+1 (L = lead_cycles), with col_valid high.
REQ-026 Each column SHALL stay on col_out for exactly H clocks (H = effective hold), then column k+1 shall follow with no gap.
REQ-027 After the last column's H clocks, the FSM SHALL enter DONE for one cycle: done=1, busy=0 in that cycle, col_out zero; then IDLE.
REQ-028 start in the DONE cycle SHALL be accepted as in IDLE.
REQ-029 Column store SHALL use a synchronous read with one-cycle latency; prefetch SHALL make REQ-026 hold with no bubble.
REQ-030 A write to the address read in the same cycle SHALL return old data; writes are allowed while busy.
REQ-031 wr_addr >= DEPTH SHALL be ignored.
REQ-032 Hold counter and column index SHALL not wrap: index stops at num_cols-1.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, col_out=0, col_valid=0, col_idx=0, busy=0, done=0, counters and latched parameters to 0.
REQ-034 Reset mid-stream SHALL abort without a done pulse; store contents are undefined.
REQ-035 After rst_n rises, the first start SHALL be accepted on the next edge.

Structure
REQ-036 Shared package SHALL hold DATA_W, DEPTH, ADDR_W defaults and the state enumeration.
REQ-037 Column store SHALL be the sub-module column_ram (1 write port, 1 synchronous read port).

Verification
REQ-038 Load cols 0..3 = 33'h1_0000_0001, 33'h0_FFFF_0000, 33'h1_AAAA_AAAA, 33'h0_0000_0003; start with num_cols=4, hold=5, lead=5 -> 5 zero clocks, each column for 5 clocks, done at start+26.
REQ-039 num_cols=0, start -> done at next edge+1, col_valid never high.
REQ-040 hold=0, num_cols=2 -> each column for 1 clock, done 3 clocks after start with lead=0.
REQ-041 Second start during streaming -> ignored, sequence unchanged; start in DONE cycle -> new stream begins.
REQ-042 rst_n low at column 2 of 4 -> outputs zero asynchronously, no done, busy low.
REQ-043 num_cols=255 with DEPTH=252 -> exactly 252 columns, last col_idx=251.

Source files
------------

// File: rtl/column_streamer_pkg.sv
// rtl/column_streamer_pkg.sv - shared defaults and FSM state encoding for column_streamer
// Purpose: single home for the column geometry defaults and the sequencer
//          state enumeration used by column_streamer.
// Ports:   none (package).
package column_streamer_pkg;

  localparam int DATA_W_DEF = 33;   // bits per bitmap column
  localparam int DEPTH_DEF  = 252;  // column storage entries
  localparam int ADDR_W_DEF = 8;    // address and count width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_SHOW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/column_ram.sv
// rtl/column_ram.sv - column store, one write port and one registered read port
// Purpose: holds the bitmap columns. Reads are synchronous with one clock of
//          latency; a read and a write to the same address in the same cycle
//          return the old contents. Out-of-range writes are dropped.
// Ports:   i_clk                 clock
//          i_wr_en/addr/data     write port
//          i_rd_addr             read address, sampled every rising edge
//          o_rd_data             read data, valid one clock after i_rd_addr
module column_ram #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 252,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Both statements use the pre-edge array contents, giving read-old-data
  // behaviour on a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (32'(i_wr_addr) < DEPTH)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (32'(i_rd_addr) < DEPTH) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/column_streamer.sv
// rtl/column_streamer.sv - streams stored bitmap columns with lead-in and per-column hold
// Purpose: on start, waits lead_cycles blank clocks, then presents columns
//          0..num_cols-1 on a registered output, each held hold_cycles clocks,
//          followed by a one-cycle done pulse.
// Ports:   clk, rst_n                    clock, async active-low reset
//          wr_en/wr_addr/wr_data         column store write port
//          start, num_cols,
//          hold_cycles, lead_cycles      stream request (parameters sampled with start)
//          col_out, col_valid, col_idx   column currently presented downstream
//          busy, done                    stream status
module column_streamer
  import column_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_cols,
  input  logic [ADDR_W-1:0] hold_cycles,
  input  logic [ADDR_W-1:0] lead_cycles,
  output logic [DATA_W-1:0] col_out,
  output logic              col_valid,
  output logic [ADDR_W-1:0] col_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_num;          // clamped column count
  logic [ADDR_W-1:0] r_hold;         // effective hold (>= 1)
  logic [ADDR_W-1:0] r_cnt;          // lead countdown, then hold countdown
  logic [ADDR_W-1:0] r_next_rd;      // next column to fetch; drives the RAM read address
  logic [ADDR_W-1:0] r_load_idx;     // index of the column arriving from the RAM
  logic              r_load_pending; // RAM output carries a fetched column this cycle
  logic [DATA_W-1:0] r_col_out;
  logic              r_col_valid;
  logic [ADDR_W-1:0] r_col_idx;

  logic [ADDR_W-1:0] w_num_in;
  logic [ADDR_W-1:0] w_hold_in;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_accept;
  logic              w_issue;
  logic              w_finish;

  assign w_num_in  = (num_cols > DEPTH_A) ? DEPTH_A : num_cols;
  assign w_hold_in = (hold_cycles == '0) ? ADDR_W'(1) : hold_cycles;
  // A zero hold count in SHOW means the last column has served its full hold.
  assign w_finish  = (r_state == ST_SHOW) && (r_cnt == '0);

  column_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_column_ram (
    .i_clk     (clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_next_rd),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // w_issue marks the edge at which the RAM samples the next column's address;
  // that column is loaded into col_out one edge later. Issue edges are spaced
  // exactly one hold apart, so the fetch is always one cycle ahead of display.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_next_state = ST_IDLE;
        if (start) begin
          w_accept = 1'b1;
          if (w_num_in == '0) begin
            w_next_state = ST_DONE;
          end else if (lead_cycles == '0) begin
            w_next_state = ST_SHOW;
            w_issue      = 1'b1;
          end else begin
            w_next_state = ST_LEAD;
          end
        end
      end
      ST_LEAD: begin
        if (r_cnt == ADDR_W'(1)) begin
          w_next_state = ST_SHOW;
          w_issue      = 1'b1;
        end
      end
      ST_SHOW: begin
        if (w_finish) begin
          w_next_state = ST_DONE;
        end else if ((r_cnt == ADDR_W'(1)) && (r_next_rd < r_num)) begin
          w_issue = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num          <= '0;
      r_hold         <= '0;
      r_cnt          <= '0;
      r_next_rd      <= '0;
      r_load_idx     <= '0;
      r_load_pending <= 1'b0;
    end else begin
      r_load_pending <= w_issue;
      if (w_accept) begin
        r_num  <= w_num_in;
        r_hold <= w_hold_in;
      end
      if (w_issue) begin
        r_cnt      <= w_accept ? w_hold_in : r_hold;
        r_next_rd  <= r_next_rd + ADDR_W'(1);
        r_load_idx <= r_next_rd;
      end else if (w_accept) begin
        r_cnt     <= (w_num_in == '0) ? '0 : lead_cycles;
        r_next_rd <= '0;
      end else if (w_finish) begin
        r_next_rd <= '0;
      end else if (((r_state == ST_LEAD) || (r_state == ST_SHOW)) && (r_cnt != '0)) begin
        // After the last issue the hold count runs down to zero and parks there.
        r_cnt <= r_cnt - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_out   <= '0;
      r_col_valid <= 1'b0;
      r_col_idx   <= '0;
    end else if (r_load_pending) begin
      r_col_out   <= w_rd_data;
      r_col_valid <= 1'b1;
      r_col_idx   <= r_load_idx;
    end else if (w_finish) begin
      r_col_out   <= '0;
      r_col_valid <= 1'b0;
    end
  end

  assign col_out   = r_col_out;
  assign col_valid = r_col_valid;
  assign col_idx   = r_col_idx;
  assign busy      = (r_state == ST_LEAD) || (r_state == ST_SHOW);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_column_streamer.sv
// tb/tb_column_streamer.sv - scoreboard bench for column_streamer
module tb_column_streamer;
  localparam int DW  = 33;
  localparam int AW  = 8;
  localparam int DEP = 252;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] num_cols = '0;
  logic [AW-1:0] hold_cycles = '0;
  logic [AW-1:0] lead_cycles = '0;
  logic [DW-1:0] col_out;
  logic          col_valid;
  logic [AW-1:0] col_idx;
  logic          busy;
  logic          done;

  column_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .num_cols    (num_cols),
    .hold_cycles (hold_cycles),
    .lead_cycles (lead_cycles),
    .col_out     (col_out),
    .col_valid   (col_valid),
    .col_idx     (col_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
  } exp_t;

  exp_t          col_q[$];
  int            done_q[$];
  exp_t          mon_e;
  logic [DW-1:0] shadow [DEP];
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented column and every done pulse against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (col_valid) begin
        if (col_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_col: idx %0d data %h at cycle %0d, none expected", col_idx, col_out, cyc);
        end else begin
          mon_e = col_q.pop_front();
          check("col_cycle", cyc, mon_e.cyc);
          check("col_data", col_out, mon_e.data);
          check("col_idx", col_idx, mon_e.idx);
        end
      end else begin
        check("blank_zero", col_out, 0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
        check("done_busy", busy, 0);
      end
    end
  end

  task automatic write_col(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < DEP) shadow[a] = d;
  endtask

  // Called just after a rising edge; start is sampled at the following edge E0.
  // Column 0 shows after edge E0+L+1, done after E0+L+1+N*H (after E0 if N=0).
  task automatic issue(input int n, input int h, input int l);
    int ne;
    int he;
    int cs;
    ne = (n > DEP) ? DEP : n;
    he = (h == 0) ? 1 : h;
    cs = cyc;
    if (ne == 0) begin
      done_q.push_back(cs + 1);
    end else begin
      for (int k = 0; k < ne; k++)
        for (int j = 0; j < he; j++)
          col_q.push_back('{cs + l + 2 + k * he + j, shadow[k], AW'(k)});
      done_q.push_back(cs + l + 2 + ne * he);
    end
    start       = 1'b1;
    num_cols    = AW'(n);
    hold_cycles = AW'(h);
    lead_cycles = AW'(l);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, (ne != 0));
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!seen && done) seen = 1'b1;
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", limit, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int cs;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col_out", col_out, 0);
    check("rst_col_valid", col_valid, 0);
    check("rst_col_idx", col_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic stream: 5 blank clocks, 4 columns x 5 clocks, done at start+26.
    write_col(0, 33'h1_0000_0001);
    write_col(1, 33'h0_FFFF_0000);
    write_col(2, 33'h1_AAAA_AAAA);
    write_col(3, 33'h0_0000_0003);
    issue(4, 5, 5);
    wait_done(100);
    @(posedge clk); #1;

    // Zero columns: straight to DONE.
    issue(0, 3, 3);
    wait_done(10);
    repeat (3) @(posedge clk);
    #1;

    // Zero hold treated as one clock.
    issue(2, 0, 0);
    wait_done(20);
    @(posedge clk); #1;

    // Start while busy is ignored; start in the DONE cycle is accepted.
    issue(3, 2, 1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; num_cols = 8'd1; hold_cycles = 8'd7; lead_cycles = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    issue(2, 1, 2);
    wait_done(50);
    @(posedge clk); #1;

    // Reset in the middle of column 2.
    cs = cyc;
    issue(4, 5, 5);
    while (cyc < cs + 19) begin
      @(posedge clk); #1;
    end
    check("pre_reset_idx", col_idx, 2);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_col_out", col_out, 0);
    check("abort_col_valid", col_valid, 0);
    check("abort_col_idx", col_idx, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    col_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First start after reset is accepted at the next edge.
    issue(0, 1, 1);
    wait_done(10);
    @(posedge clk); #1;

    // Clamp: 255 requested, 252 shown; out-of-range writes dropped.
    for (int k = 0; k < DEP; k++)
      write_col(k, {k[0], 32'h1000_0000 + 32'(k) * 32'h0101_0101});
    write_col(252, '1);
    write_col(255, '1);
    issue(255, 0, 0);
    wait_done(400);
    repeat (5) @(posedge clk);
    #1;

    check("cols_outstanding", col_q.size(), 0);
    check("done_outstanding", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
